// File: rtl/control_sequencer_pkg.sv
// sap1_pkg: shared constants and types for the SAP-1 control sequencer.
// Holds opcodes, control-word bit positions, one-hot T-state constants,
// the control-word type, the halt FSM state type and a T-state index helper.
package sap1_pkg;

    // Opcodes (upper nibble of IR); anything else behaves as a NOP
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Control-word bit positions, all active-high
    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    // One-hot T-state encodings from the ring counter
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    typedef logic [11:0] ctrl_word_t;

    // Halt tracking: the sequencer either runs or sits halted until reset
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } halt_state_t;

    // T-state number 1..6 of the lowest set bit; 0 when no bit is set
    function automatic logic [2:0] tstate_index(input logic [5:0] t);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (t[i]) idx = 3'(i + 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: bundle between the ring counter/IR side and the
// control sequencer. There is no handshake on this bus: t_state and opcode
// are level signals that change on negedge and are sampled on posedge, and
// every output is either combinational from them or registered on posedge.
// The master modport is the ring counter/IR side, slave is the sequencer.
interface control_sequencer_if
    import sap1_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic [5:0]       t_state;
    logic [3:0]       opcode;
    ctrl_word_t       ctrl_word;
    logic             ring_en;
    logic             halted;
    logic [CNT_W-1:0] instr_count;
    logic             tstate_err;

    modport master (
        output t_state,
        output opcode,
        input  ctrl_word,
        input  ring_en,
        input  halted,
        input  instr_count,
        input  tstate_err
    );

    modport slave (
        input  t_state,
        input  opcode,
        output ctrl_word,
        output ring_en,
        output halted,
        output instr_count,
        output tstate_err
    );
endinterface

// File: rtl/control_sequencer_cw_decode.sv
// cw_decode: purely combinational (T-state index, opcode) -> control word.
// tidx is 1..6 for T1..T6 and 0 for "no T-state", which yields a zero word.
module cw_decode
    import sap1_pkg::*;
(
    input  logic [2:0] tidx,
    input  logic [3:0] opcode,
    output ctrl_word_t cw
);

    // Fetch is common to all opcodes; execute phases depend on the opcode
    always_comb begin
        cw = '0;
        case (tidx)
            3'd1: begin
                cw[CW_EP] = 1'b1;
                cw[CW_LM] = 1'b1;
            end
            3'd2: cw[CW_CP] = 1'b1;
            3'd3: begin
                cw[CW_CE] = 1'b1;
                cw[CW_LI] = 1'b1;
            end
            3'd4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        cw[CW_LM] = 1'b1;
                        cw[CW_EI] = 1'b1;
                    end
                    OP_OUT: begin
                        cw[CW_EA] = 1'b1;
                        cw[CW_LO] = 1'b1;
                    end
                    default: ;
                endcase
            end
            3'd5: begin
                case (opcode)
                    OP_LDA: begin
                        cw[CW_CE] = 1'b1;
                        cw[CW_LA] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_CE] = 1'b1;
                        cw[CW_LB] = 1'b1;
                    end
                    default: ;
                endcase
            end
            3'd6: begin
                case (opcode)
                    OP_ADD: begin
                        cw[CW_EU] = 1'b1;
                        cw[CW_LA] = 1'b1;
                    end
                    OP_SUB: begin
                        cw[CW_EU] = 1'b1;
                        cw[CW_LA] = 1'b1;
                        cw[CW_SU] = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: decodes the one-hot T-state and IR opcode into the SAP-1
// control word, tracks halt, counts retired instructions and, when
// CTRL_TSTATE_CHECK_EN is defined, flags malformed T-state encodings.
// Without CTRL_TSTATE_CHECK_EN a malformed T-state decodes as its lowest
// set bit and tstate_err is tied low. The halt FSM state is visible on halted.
module control_sequencer
    import sap1_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    control_sequencer_if.slave  bus
);

    logic [2:0]       tidx;
    ctrl_word_t       cw_raw;
    halt_state_t      state_q;
    halt_state_t      state_d;
    logic [CNT_W-1:0] count_q;
    logic             halted;

`ifdef CTRL_TSTATE_CHECK_EN
    logic one_hot;
    logic err_q;

    // A malformed T-state is treated as "no T-state": no bits, no count, no halt
    always_comb begin
        one_hot = $onehot(bus.t_state);
        tidx    = one_hot ? tstate_index(bus.t_state) : 3'd0;
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (!one_hot) begin
            err_q <= 1'b1;
        end
    end

    assign bus.tstate_err = err_q;
`else
    // Lowest set bit wins; all-zero decodes as no T-state
    assign tidx           = tstate_index(bus.t_state);
    assign bus.tstate_err = 1'b0;
`endif

    cw_decode u_cw_decode (
        .tidx   (tidx),
        .opcode (bus.opcode),
        .cw     (cw_raw)
    );

    // Halt FSM state register; only reset leaves ST_HALT
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Halt FSM next state: HLT in T4 halts at that posedge
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (tidx == 3'd4 && bus.opcode == OP_HLT) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    assign halted = (state_q == ST_HALT);

    // Retired-instruction counter: one count per T6 while running, wraps silently
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (!halted && tidx == 3'd6) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.ctrl_word   = (reset || halted) ? '0 : cw_raw;
    assign bus.ring_en     = !halted && !reset;
    assign bus.halted      = halted;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and randomized checking of control_sequencer
// against a behavioural model (T-state/opcode table plus halt/count/error
// bookkeeping). Honours CTRL_TSTATE_CHECK_EN for the malformed-T-state rules.
module tb_control_sequencer;

    localparam int CNT_W = 8;
    localparam int CNT_MOD = 1 << CNT_W;

    logic clk;
    logic reset;

    control_sequencer_if #(.CNT_W(CNT_W)) bus ();

    control_sequencer #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model state
    logic m_halted = 1'b0;
    int   m_cnt = 0;
    logic m_err = 1'b0;

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Control word the spec lists for T-state n (1..6, 0 = none) and opcode
    function automatic logic [11:0] model_cw(input int n, input logic [3:0] op);
        case (n)
            1: return 12'h600;
            2: return 12'h800;
            3: return 12'h180;
            4: begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) return 12'h240;
                if (op == 4'hE) return 12'h011;
                return 12'h000;
            end
            5: begin
                if (op == 4'h0) return 12'h120;
                if (op == 4'h1 || op == 4'h2) return 12'h102;
                return 12'h000;
            end
            6: begin
                if (op == 4'h1) return 12'h024;
                if (op == 4'h2) return 12'h02C;
                return 12'h000;
            end
            default: return 12'h000;
        endcase
    endfunction

    // T-state number seen by the model (malformed handling per build option)
    function automatic int model_tnum(input logic [5:0] t);
        int n;
        n = 0;
`ifdef CTRL_TSTATE_CHECK_EN
        if ($countones(t) != 1) return 0;
`endif
        for (int i = 0; i < 6; i++) begin
            if (t[i]) begin
                n = i + 1;
                break;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: update model at each posedge, compare all outputs just after
    initial begin
        logic       r;
        logic [5:0] t;
        logic [3:0] op;
        int         n;
        logic [11:0] exp_cw;
        forever begin
            @(posedge clk);
            r  = reset;
            t  = bus.t_state;
            op = bus.opcode;
            if (r) begin
                m_halted = 1'b0;
                m_cnt    = 0;
                m_err    = 1'b0;
            end else begin
                n = model_tnum(t);
`ifdef CTRL_TSTATE_CHECK_EN
                if ($countones(t) != 1) m_err = 1'b1;
`endif
                if (!m_halted) begin
                    if (n == 6) m_cnt = (m_cnt + 1) % CNT_MOD;
                    if (n == 4 && op == 4'hF) m_halted = 1'b1;
                end
            end
            #1;
            exp_cw = (reset || m_halted) ? 12'h000 : model_cw(model_tnum(bus.t_state), bus.opcode);
            chk("ctrl_word", bus.ctrl_word, exp_cw);
            chk("ring_en", bus.ring_en, !m_halted && !reset);
            chk("halted", bus.halted, m_halted);
            chk("instr_count", bus.instr_count, m_cnt);
            chk("tstate_err", bus.tstate_err, m_err);
        end
    end

    // Driver: apply one T-state cycle on the negedge
    task automatic step(input logic [5:0] t, input logic [3:0] op, input logic rst);
        @(negedge clk);
        bus.t_state = t;
        bus.opcode  = op;
        reset       = rst;
    endtask

    task automatic run_instr(input logic [3:0] op);
        for (int i = 0; i < 6; i++) step(6'(1 << i), op, 1'b0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    logic [11:0] lda_exp [6];
    logic [3:0]  rop;
    logic [5:0]  rt;

    initial begin
        lda_exp = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h120, 12'h000};
        reset       = 1'b1;
        bus.t_state = 6'b000001;
        bus.opcode  = 4'h0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ctrl", bus.ctrl_word, 12'h000);
        chk("rst_ring_en", bus.ring_en, 1'b0);
        chk("rst_halted", bus.halted, 1'b0);
        chk("rst_count", bus.instr_count, 0);
        chk("rst_err", bus.tstate_err, 1'b0);

        // LDA fetch/execute literals
        for (int i = 0; i < 6; i++) begin
            step(6'(1 << i), 4'h0, 1'b0);
            #1;
            chk($sformatf("lda_t%0d", i + 1), bus.ctrl_word, lda_exp[i]);
        end
        after_edge();
        chk("lda_count", bus.instr_count, 1);

        // ADD, SUB, OUT literals
        for (int i = 0; i < 6; i++) begin
            step(6'(1 << i), 4'h1, 1'b0);
            #1;
            if (i == 4) chk("add_t5", bus.ctrl_word, 12'h102);
            if (i == 5) chk("add_t6", bus.ctrl_word, 12'h024);
        end
        for (int i = 0; i < 6; i++) begin
            step(6'(1 << i), 4'h2, 1'b0);
            #1;
            if (i == 5) chk("sub_t6", bus.ctrl_word, 12'h02C);
        end
        for (int i = 0; i < 6; i++) begin
            step(6'(1 << i), 4'hE, 1'b0);
            #1;
            if (i == 3) chk("out_t4", bus.ctrl_word, 12'h011);
        end
        after_edge();
        chk("count_4", bus.instr_count, 4);

        // Fill to 255, then wrap
        for (int k = 0; k < 251; k++) run_instr(4'($urandom_range(0, 14)));
        after_edge();
        chk("count_255", bus.instr_count, 255);
        run_instr(4'h0);
        after_edge();
        chk("count_wrap", bus.instr_count, 0);

        // Malformed T-state in T1 position
        step(6'b000011, 4'h0, 1'b0);
        #1;
`ifdef CTRL_TSTATE_CHECK_EN
        chk("bad_ts_ctrl", bus.ctrl_word, 12'h000);
`else
        chk("bad_ts_ctrl", bus.ctrl_word, 12'h600);
`endif
        after_edge();
`ifdef CTRL_TSTATE_CHECK_EN
        chk("bad_ts_err", bus.tstate_err, 1'b1);
`else
        chk("bad_ts_err", bus.tstate_err, 1'b0);
`endif
        for (int i = 1; i < 6; i++) step(6'(1 << i), 4'h0, 1'b0);
        after_edge();
        chk("bad_ts_count", bus.instr_count, 1);
`ifdef CTRL_TSTATE_CHECK_EN
        chk("bad_ts_sticky", bus.tstate_err, 1'b1);
`endif

        // Reset during ADD T5
        for (int i = 0; i < 4; i++) step(6'(1 << i), 4'h1, 1'b0);
        step(6'b010000, 4'h1, 1'b1);
        #1;
        chk("rst_mid_ctrl", bus.ctrl_word, 12'h000);
        after_edge();
        chk("rst_mid_count", bus.instr_count, 0);
        chk("rst_mid_err", bus.tstate_err, 1'b0);
        chk("rst_mid_halted", bus.halted, 1'b0);

        // LDA then HLT: halt at T4, everything frozen afterwards
        run_instr(4'h0);
        for (int i = 0; i < 4; i++) step(6'(1 << i), 4'hF, 1'b0);
        after_edge();
        chk("hlt_halted", bus.halted, 1'b1);
        chk("hlt_ring_en", bus.ring_en, 1'b0);
        step(6'b010000, 4'hF, 1'b0);
        step(6'b100000, 4'hF, 1'b0);
        run_instr(4'h1);
        step(6'b000001, 4'h0, 1'b0);
        #1;
        chk("hlt_ctrl", bus.ctrl_word, 12'h000);
        chk("hlt_count", bus.instr_count, 1);

        // Randomized phase
        step(6'b000001, 4'h0, 1'b1);
        for (int k = 0; k < 400; k++) begin
            if (m_halted && $urandom_range(0, 3) == 0) step(6'b000001, 4'h0, 1'b1);
            rop = 4'($urandom_range(0, 15));
            for (int i = 0; i < 6; i++) begin
                rt = 6'(1 << i);
                if ($urandom_range(0, 49) == 0) rt = 6'($urandom_range(0, 63));
                if ($urandom_range(0, 19) == 0) rop = 4'($urandom_range(0, 15));
                step(rt, rop, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
            end
        end
        after_edge();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Consumer of the 6-bit one-hot T-state bus produced by the SAP-1 ring counter. It decodes the current T-state and the instruction-register opcode into the 12-bit control word that drives the PC, MAR, RAM, IR, accumulator, ALU, B and output registers. It also tracks halt, counts retired instructions and flags malformed T-state encodings. It sits between the ring counter/IR and every datapath register.

## Interface
Parameters:
- CNT_W, 8, width of the retired-instruction counter

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- t_state  in  6  one-hot T-state (bit0 = T1 … bit5 = T6); changes on negedge, stable at posedge
- opcode  in  4  upper nibble of IR
- ctrl_word  out  12  control word, all bits active-high: [11] cp, [10] ep, [9] lm, [8] ce, [7] li, [6] ei, [5] la, [4] ea, [3] su, [2] eu, [1] lb, [0] lo
- ring_en  out  1  high = ring counter may advance; low once halted
- halted  out  1  registered halt flag
- instr_count  out  CNT_W  retired-instruction count
- tstate_err  out  1  sticky malformed-T-state flag

## Operation
- Opcodes: LDA 4'h0, ADD 4'h1, SUB 4'h2, OUT 4'hE, HLT 4'hF; all others are NOP (no control bits in T4–T6).
- Fetch, every opcode: T1 ep+lm; T2 cp; T3 ce+li.
- LDA: T4 lm+ei; T5 ce+la; T6 none.
- ADD: T4 lm+ei; T5 ce+lb; T6 eu+la.
- SUB: as ADD, plus su in T6.
- OUT: T4 ea+lo; T5, T6 none.
- HLT: T4 none; halted set at the T4 posedge.
- While halted or reset high: ctrl_word = 0, ring_en = 0 (while reset high, ring_en = 0 too).
- halted is cleared only by reset.
- instr_count increments by 1 at each posedge with t_state = T6 and halted = 0. It wraps from 2^CNT_W−1 to 0 with no flag.
- HLT never reaches T6, so it is not counted.

## Timing
- ctrl_word is combinational from t_state, opcode and halted: zero-cycle latency, valid before the posedge that consumes it.
- halted, instr_count and tstate_err are registered and update on posedge clk.
- ring_en = !halted && !reset. It drops in the cycle after the HLT T4 posedge.
- Reset values: halted 0, instr_count 0, tstate_err 0, ctrl_word 0, ring_en 0.
- Reset asserted mid-instruction: the next posedge clears all state and ctrl_word is 0 immediately. No partial instruction is counted.
- opcode changes outside T3/T4–T6 boundaries are not filtered. Decode follows the opcode present at each posedge.

## Configuration
- Macro CTRL_TSTATE_CHECK_EN.
- Defined:
  - At each posedge with reset low, t_state that is not exactly one-hot (zero or multiple bits) sets tstate_err, which is sticky until reset.
  - During any non-one-hot cycle, ctrl_word is forced to 0 and instr_count does not increment.
- Undefined:
  - tstate_err is tied 0.
  - A non-one-hot t_state decodes as its lowest set bit; all-zero decodes as no T-state (ctrl_word 0).

## Structure
- Package sap1_pkg holds:
  - opcode localparams
  - control-word bit-index constants
  - T1..T6 one-hot constants
  - the 12-bit control-word typedef
- Sub-module cw_decode: purely combinational (t_state index, opcode) → control word.
- The top level holds the halt register, counter, error logic and output gating.

## Test plan
- Reset high two cycles, then low with t_state cycling T1..T6 and opcode 4'h0 → ctrl_word 12'h600, 12'h800, 12'h180, 12'h240, 12'h120, 12'h000 in order; instr_count 1 after the T6 posedge.
- SUB sequence → T6 ctrl_word 12'h02C (la|su|eu); ADD T6 → 12'h024; instr_count increments once per instruction.
- HLT at T4 → halted = 1 and ring_en = 0 from the next cycle; ctrl_word 0 thereafter with t_state still toggling; instr_count frozen.
- Preset instr_count to 255 (CNT_W=8) by 255 instructions, one more → 0.
- With CTRL_TSTATE_CHECK_EN, drive t_state 6'b000011 for one cycle → ctrl_word 0 that cycle and tstate_err = 1, remaining 1 until reset. Without the macro → ctrl_word 12'h600 and tstate_err 0.
- Assert reset during ADD T5 → next cycle halted 0, instr_count 0, tstate_err 0, ctrl_word 0 while reset high.
